// File: rtl/game_ui_scheduler.sv
// game_ui_scheduler
//   Walks the UI ROM reader through its entry list. Each entry is fetched,
//   announced to the display logic with a one-cycle ui_apply, then held until
//   game time reaches the entry's release time. At the end marker the
//   scheduler stops in DONE or wraps back to address 0.
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   start            pulse: run from address 0 (honoured only in IDLE/DONE)
//   restart          pulse: abort whatever is happening and re-run from 0
//   pause            level: holds an armed entry
//   loop_enable      end-marker behaviour: 1 = wrap to 0, 0 = stop in DONE
//   current_time     game time from the runtime timebase
//   update_ui_time   reader: next_ui_time / is_end valid for addr
//   next_ui_time     reader: release time of the entry at addr
//   is_end           reader: entry at addr is the end marker
//   addr             reader address
//   sync_ui_time     acknowledge/clear to reader
//   ui_apply         pulse: reader UI outputs valid for addr
//   busy, done       status (busy outside IDLE/DONE, done in DONE)
//   timeout_err      sticky reader-timeout flag
//   entry_count      entries applied since last start/restart (saturating)
//   dbg_state        current FSM state (0 IDLE, 1 WAIT_READ, 2 ARMED,
//                    3 ACK, 4 DONE)
//
// Reader handshake: sync_ui_time=1 clears the reader and makes it drop
// update_ui_time; sync_ui_time=0 lets it fetch addr and raise update_ui_time,
// which it holds until sync_ui_time rises again. A new fetch only starts
// once update_ui_time has been seen low with addr already stable.
module game_ui_scheduler #(
  parameter int ADDR_WIDTH     = 10,
  parameter int MAXIMUM_TIMES  = 30,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     restart,
  input  logic                     pause,
  input  logic                     loop_enable,
  input  logic [MAXIMUM_TIMES-1:0] current_time,
  input  logic                     update_ui_time,
  input  logic [MAXIMUM_TIMES-1:0] next_ui_time,
  input  logic                     is_end,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     sync_ui_time,
  output logic                     ui_apply,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [15:0]              entry_count,
  output logic [2:0]               dbg_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_READ = 3'd1,
    S_ARMED     = 3'd2,
    S_ACK       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                   r_state, w_state_n;
  logic [ADDR_WIDTH-1:0]    r_addr, w_addr_n;
  logic                     r_sync, w_sync_n;
  logic                     r_apply, w_apply_n;
  logic                     r_busy, w_busy_n;
  logic                     r_done, w_done_n;
  logic                     r_terr, w_terr_n;
  logic [15:0]              r_count, w_count_n;
  logic [MAXIMUM_TIMES-1:0] r_target, w_target_n;
  logic [WD_W-1:0]          r_wd, w_wd_n;
  // High on the first ACK cycle so ACK always lasts at least two cycles.
  logic                     r_ack_first, w_ack_first_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_sync      <= 1'b1;
      r_apply     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_terr      <= 1'b0;
      r_count     <= '0;
      r_target    <= '0;
      r_wd        <= '0;
      r_ack_first <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_addr      <= w_addr_n;
      r_sync      <= w_sync_n;
      r_apply     <= w_apply_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_terr      <= w_terr_n;
      r_count     <= w_count_n;
      r_target    <= w_target_n;
      r_wd        <= w_wd_n;
      r_ack_first <= w_ack_first_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_addr_n      = r_addr;
    w_sync_n      = r_sync;
    w_apply_n     = 1'b0;
    w_count_n     = r_count;
    w_terr_n      = r_terr;
    w_target_n    = r_target;
    w_wd_n        = r_wd;
    w_ack_first_n = 1'b0;

    if (restart) begin
      // Restart beats start and every state; pending target is dropped.
      w_state_n     = S_ACK;
      w_addr_n      = '0;
      w_count_n     = '0;
      w_terr_n      = 1'b0;
      w_wd_n        = '0;
      w_target_n    = '0;
      w_sync_n      = 1'b1;
      w_ack_first_n = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          w_sync_n = 1'b1;
          if (start) begin
            w_state_n = S_WAIT_READ;
            w_addr_n  = '0;
            w_sync_n  = 1'b0;
            w_count_n = '0;
            w_terr_n  = 1'b0;
            w_wd_n    = '0;
          end
        end
        S_WAIT_READ: begin
          w_sync_n = 1'b0;
          if (update_ui_time) begin
            w_target_n = next_ui_time;
            w_wd_n     = '0;
            if (!is_end) begin
              w_apply_n = 1'b1;
              w_state_n = S_ARMED;
              if (r_count != 16'hFFFF) w_count_n = r_count + 16'd1;
            end else if (loop_enable) begin
              w_addr_n      = '0;
              w_state_n     = S_ACK;
              w_sync_n      = 1'b1;
              w_ack_first_n = 1'b1;
            end else begin
              w_state_n = S_DONE;
              w_sync_n  = 1'b1;
            end
          end else if (r_wd == WD_LAST) begin
            w_terr_n  = 1'b1;
            w_state_n = S_IDLE;
            w_sync_n  = 1'b1;
            w_wd_n    = '0;
          end else begin
            w_wd_n = r_wd + 1'b1;
          end
        end
        S_ARMED: begin
          w_sync_n = 1'b0;
          if (!pause && (current_time >= r_target)) begin
            // Address wraps naturally at the top of the ROM.
            w_addr_n      = r_addr + 1'b1;
            w_state_n     = S_ACK;
            w_sync_n      = 1'b1;
            w_ack_first_n = 1'b1;
          end
        end
        S_ACK: begin
          w_sync_n = 1'b1;
          if (!r_ack_first && !update_ui_time) begin
            w_state_n = S_WAIT_READ;
            w_sync_n  = 1'b0;
            w_wd_n    = '0;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_sync_n  = 1'b1;
        end
      endcase
    end

    w_busy_n = (w_state_n != S_IDLE) && (w_state_n != S_DONE);
    w_done_n = (w_state_n == S_DONE);
  end

  assign addr         = r_addr;
  assign sync_ui_time = r_sync;
  assign ui_apply     = r_apply;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_err  = r_terr;
  assign entry_count  = r_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_game_ui_scheduler.sv
// Bench for game_ui_scheduler: reader model, timebase, scoreboard monitor.
module tb_game_ui_scheduler;
  localparam int AW = 3;
  localparam int TW = 30;
  localparam int TO = 16;
  localparam int W  = AW + 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          restart = 1'b0;
  logic          pause = 1'b0;
  logic          loop_enable = 1'b0;
  logic [TW-1:0] current_time = '0;
  logic          update_ui_time = 1'b0;
  logic [TW-1:0] next_ui_time = '0;
  logic          is_end = 1'b0;
  logic [AW-1:0] addr;
  logic          sync_ui_time, ui_apply, busy, done, timeout_err;
  logic [15:0]   entry_count;
  logic [2:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0]  exp_q[$];          // {entry_count, addr} per expected ui_apply
  logic [TW-1:0] mem_t[8];
  logic          mem_e[8];
  int  time_step = 1;               // <0 means random 0..3 per cycle
  int  pause_mode = 0;              // 0 off, 1 window 70..120, 2 random
  bit  time_zero = 1'b1;
  int  rd_lat = 0;
  int  rd_fall = 0;
  bit  rd_silent = 1'b0;
  int  rel_time = -1;

  game_ui_scheduler #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .restart(restart), .pause(pause),
    .loop_enable(loop_enable), .current_time(current_time),
    .update_ui_time(update_ui_time), .next_ui_time(next_ui_time), .is_end(is_end),
    .addr(addr), .sync_ui_time(sync_ui_time), .ui_apply(ui_apply), .busy(busy),
    .done(done), .timeout_err(timeout_err), .entry_count(entry_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required to finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; time_zero = 1'b1; start = 1'b0; restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; time_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- timebase driver ----------------
  initial begin : timebase
    forever begin
      @(posedge clk);
      #1;
      if (time_zero) current_time = '0;
      else if (time_step < 0) current_time = current_time + TW'($urandom_range(0, 3));
      else current_time = current_time + TW'(time_step);
      case (pause_mode)
        1: pause = (current_time >= 70) && (current_time <= 120);
        2: pause = ($urandom_range(0, 3) == 0);
        default: pause = 1'b0;
      endcase
    end
  end

  // ---------------- reader model ----------------
  initial begin : reader
    int lat;
    int fl;
    lat = 0; fl = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        update_ui_time = 1'b0; lat = 0; fl = 0;
      end else if (sync_ui_time) begin
        lat = 0;
        if (update_ui_time) begin
          if (fl >= rd_fall) begin update_ui_time = 1'b0; fl = 0; end
          else fl++;
        end
      end else if (!update_ui_time && !rd_silent) begin
        fl = 0;
        if (lat >= rd_lat) begin
          update_ui_time = 1'b1;
          next_ui_time   = mem_t[addr];
          is_end         = mem_e[addr];
          lat = 0;
        end else lat++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic          armed, prev_pause, prev_restart, prev_sync, rel;
    logic [TW-1:0] tgt, prev_time;
    logic [AW-1:0] prev_addr, nxt;
    logic [W-1:0]  e;
    int            hi_cnt;
    armed = 1'b0; prev_pause = 1'b0; prev_restart = 1'b0; prev_sync = 1'b1;
    tgt = '0; prev_time = '0; prev_addr = '0; hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 1'b0; hi_cnt = 0; prev_restart = 1'b0;
      end else begin
        // Release rule: judged on the inputs the DUT sampled at the last edge.
        if (armed && !prev_restart) begin
          rel = !prev_pause && (prev_time >= tgt);
          if (rel) begin
            nxt = prev_addr + 1'b1;
            chk("release_addr", addr, nxt);
            chk("release_sync", sync_ui_time, 1);
            rel_time = int'(prev_time);
          end else begin
            chk("hold_addr", addr, prev_addr);
            chk("hold_sync", sync_ui_time, 0);
          end
        end
        if (ui_apply) begin
          chk("apply_sync_low", sync_ui_time, 0);
          if (exp_q.size() == 0) begin
            chk("apply_unexpected_at_addr", 64'(addr), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("apply_addr", addr, e[AW-1:0]);
            chk("apply_count", entry_count, e[W-1:AW]);
          end
          tgt = mem_t[addr];
        end
        if (sync_ui_time) hi_cnt++;
        else begin
          if (prev_sync && hi_cnt > 0) chk("sync_high_min2", hi_cnt >= 2, 1);
          hi_cnt = 0;
        end
        armed = ui_apply || (armed && !sync_ui_time && !prev_restart);
      end
      prev_time = current_time; prev_pause = pause; prev_addr = addr;
      prev_restart = restart; prev_sync = sync_ui_time;
    end
  end

  // ---------------- reference model ----------------
  // Walk the entry list by the scheduling rules and list every ui_apply.
  task automatic build_exp(input bit lp, input int max_ap, output bit ed,
                           output int ea, output int n);
    int a;
    a = 0; n = 0; ed = 1'b0; ea = 0;
    for (int k = 0; k < 64 && n < max_ap && !ed; k++) begin
      if (mem_e[a]) begin
        if (lp) a = 0;
        else begin ed = 1'b1; ea = a; end
      end else begin
        n++;
        exp_q.push_back({16'(n), AW'(a)});
        a = (a + 1) % 8;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit need_done, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && (!need_done || done);
    end
    chk({name, "_in_budget"}, ok, 1);
  endtask

  task automatic run(input bit rst, input bit lp, input int max_ap, input string name);
    bit ed;
    int ea, n;
    exp_q.delete();
    build_exp(lp, max_ap, ed, ea, n);
    if (rst) do_reset();
    loop_enable = lp;
    pulse_start();
    wait_idle(4000, ed, name);
    if (ed) begin
      chk({name, "_done"}, done, 1);
      chk({name, "_addr"}, addr, ea);
      chk({name, "_count"}, entry_count, n);
      chk({name, "_sync"}, sync_ui_time, 1);
      chk({name, "_busy"}, busy, 0);
    end else begin
      chk({name, "_count"}, entry_count, n);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin mem_t[i] = '0; mem_e[i] = 1'b0; end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    clear_mem();
    do_reset();
    chk("rst_addr", addr, 0);
    chk("rst_sync", sync_ui_time, 1);
    chk("rst_apply", ui_apply, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_count", entry_count, 0);
    chk("rst_state", dbg_state, 0);

    // single entry released at exactly t=100
    clear_mem(); mem_t[0] = 100; mem_e[1] = 1'b1;
    time_step = 1; pause_mode = 0; rd_lat = 2; rd_fall = 0;
    run(1'b1, 1'b0, 8, "single");
    chk("single_release_time", 64'(rel_time), 100);

    // 50,50,200,end without looping
    clear_mem(); mem_t[0] = 50; mem_t[1] = 50; mem_t[2] = 200; mem_e[3] = 1'b1;
    rd_lat = 1; rd_fall = 1;
    run(1'b1, 1'b0, 8, "list_stop");

    // same list looping: fourth apply is entry 0 again
    run(1'b1, 1'b1, 4, "list_loop");
    chk("loop_addr", addr, 0);
    begin : async_reset_mid_ack
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        seen = sync_ui_time && busy;
      end
      chk("ack_reached", seen, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_addr", addr, 0);
      chk("arst_sync", sync_ui_time, 1);
      chk("arst_busy", busy, 0);
      chk("arst_count", entry_count, 0);
      chk("arst_done", done, 0);
      chk("arst_apply", ui_apply, 0);
    end

    // pause window holds entry at 80 until the pause drops at 121
    clear_mem(); mem_t[0] = 80; mem_e[1] = 1'b1;
    pause_mode = 1; rd_lat = 0; rd_fall = 0;
    run(1'b1, 1'b0, 8, "pause");
    chk("pause_release_time", 64'(rel_time), 121);
    pause_mode = 0;

    // silent reader: watchdog timeout after TO cycles in WAIT_READ
    begin : timeout_test
      int wcnt;
      bit hit;
      wcnt = 0; hit = 1'b0;
      exp_q.delete();
      rd_silent = 1'b1;
      do_reset();
      pulse_start();
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (timeout_err) hit = 1'b1;
        else if (busy && !sync_ui_time) wcnt++;
      end
      chk("to_flag", timeout_err, 1);
      chk("to_cycles", wcnt, TO);
      chk("to_sync", sync_ui_time, 1);
      chk("to_busy", busy, 0);
      chk("to_state_idle", dbg_state, 0);
      @(posedge clk);
      #1;
      rd_silent = 1'b0;
      clear_mem(); mem_t[0] = 10; mem_e[1] = 1'b1;
      run(1'b0, 1'b0, 8, "after_to");
      chk("to_cleared", timeout_err, 0);
    end

    // restart+start while armed at addr 5
    clear_mem();
    for (int i = 0; i < 5; i++) mem_t[i] = TW'(5 * (i + 1));
    mem_t[5] = TW'(1 << 29);
    time_step = 1; rd_lat = 1; rd_fall = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({16'(i + 1), AW'(i)});
    do_reset();
    loop_enable = 1'b0;
    pulse_start();
    wait_idle(2000, 1'b0, "rs_first");
    repeat (3) @(negedge clk);
    chk("rs_armed_addr", addr, 5);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) exp_q.push_back({16'(i + 1), AW'(i)});
    restart = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rs_addr", addr, 0);
    chk("rs_count", entry_count, 0);
    chk("rs_sync", sync_ui_time, 1);
    chk("rs_busy", busy, 1);
    chk("rs_done", done, 0);
    wait_idle(2000, 1'b0, "rs_rerun");

    // randomized lists; first one has no end marker and wraps the address
    for (int r = 0; r < 6; r++) begin
      int len, base;
      len = (r == 0) ? 8 : int'($urandom_range(2, 7));
      base = 0;
      for (int i = 0; i < 8; i++) begin
        base += int'($urandom_range(0, 40));
        mem_t[i] = ($urandom_range(0, 4) == 0) ? TW'($urandom_range(0, base)) : TW'(base);
        mem_e[i] = (i == len);
      end
      time_step = -1; pause_mode = 2;
      rd_lat = int'($urandom_range(0, 3)); rd_fall = int'($urandom_range(0, 2));
      run(1'b1, (r == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 12, "rand");
    end

    pause_mode = 0;
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
